// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared constants and helpers for the rr_mux streaming multiplexer.
// Helpers operate on MAX_CH-wide vectors; callers pass the live width in n
// and use only the low n bits of the result. Supports N_CH up to MAX_CH.
package rr_mux_pkg;

  localparam int unsigned CH_W_MIN = 1;
  localparam int unsigned MAX_CH   = 64;
  localparam int unsigned IDX_W    = 6;

  // Binary index of the set bit of a one-hot vector (0 when no bit is set).
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] onehot,
                                                     input int unsigned        n);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i < n && onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // Rotate the low n bits right by amt (amt < n): result[i] = v[(i+amt) mod n].
  function automatic logic [MAX_CH-1:0] rotate_right(input logic [MAX_CH-1:0] v,
                                                     input int unsigned        amt,
                                                     input int unsigned        n);
    logic [MAX_CH-1:0] r;
    int unsigned       j;
    r = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      j = i + amt;
      if (j >= n) j = j - n;
      if (i < n) r[i] = v[j[IDX_W-1:0]];
    end
    return r;
  endfunction

  // Inverse of rotate_right: result[(i+amt) mod n] = v[i].
  function automatic logic [MAX_CH-1:0] rotate_left(input logic [MAX_CH-1:0] v,
                                                    input int unsigned        amt,
                                                    input int unsigned        n);
    logic [MAX_CH-1:0] r;
    int unsigned       j;
    r = '0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      j = i + amt;
      if (j >= n) j = j - n;
      if (i < n) r[j[IDX_W-1:0]] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter.sv
// rr_arbiter: combinational one-hot grant generator for rr_mux.
// Default: round-robin search starting just above ptr_i, wrapping.
// RR_MUX_FIXED_PRIO_EN: fixed priority, lowest requesting index wins; ptr_i ignored.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int unsigned N_CH = 8,
  localparam int unsigned CH_W = ($clog2(N_CH) > CH_W_MIN) ? $clog2(N_CH) : CH_W_MIN
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [N_CH-1:0] grant_o
);

`ifdef RR_MUX_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr_i;

  // Isolate the lowest set request bit.
  always_comb begin
    grant_o = req_i & (~req_i + N_CH'(1));
  end

`else

  logic [MAX_CH-1:0] req_w;
  logic [MAX_CH-1:0] rot_w;
  logic [MAX_CH-1:0] first_w;
  logic [MAX_CH-1:0] back_w;
  logic [N_CH-1:0]   rot_n;
  int unsigned       start;
  logic              unused_hi;

  // Rotate so the channel after ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    start = 32'(ptr_i) + 32'd1;
    if (start >= N_CH) start = 0;
    req_w            = '0;
    req_w[N_CH-1:0]  = req_i;
    rot_w            = rotate_right(req_w, start, N_CH);
    rot_n            = rot_w[N_CH-1:0];
    first_w          = '0;
    first_w[N_CH-1:0] = rot_n & (~rot_n + N_CH'(1));
    back_w           = rotate_left(first_w, start, N_CH);
    grant_o          = back_w[N_CH-1:0];
  end

  assign unused_hi = ^{rot_w, back_w};

`endif

endmodule

// File: rtl/rr_mux.sv
// rr_mux: N_CH-channel valid/ready multiplexer with a registered output stage
// and source-channel tagging. Optional macro RR_MUX_FIXED_PRIO_EN selects
// fixed-priority arbitration instead of round-robin (ptr register removed).
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter  int unsigned N_CH   = 8,
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned CH_W   = ($clog2(N_CH) > CH_W_MIN) ? $clog2(N_CH) : CH_W_MIN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [CH_W-1:0]        out_chan,
  input  logic                   out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CH_W-1:0]   out_chan_q,  out_chan_d;
  logic [CH_W-1:0]   ptr_arb;

  logic              load;
  logic [N_CH-1:0]   grant;
  logic              xfer;
  logic [DATA_W-1:0] sel_data;
  logic [MAX_CH-1:0] grant_w;
  logic [IDX_W-1:0]  sel_idx_w;
  logic [CH_W-1:0]   sel_idx;
  logic              unused_idx;

`ifdef RR_MUX_FIXED_PRIO_EN
  assign ptr_arb = '0;
`else
  logic [CH_W-1:0] ptr_q, ptr_d;
  assign ptr_arb = ptr_q;
`endif

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req_i   (in_valid),
    .ptr_i   (ptr_arb),
    .grant_o (grant)
  );

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = grant & {N_CH{load}};
  // grant is a subset of in_valid, so any ready bit implies a transfer.
  assign xfer     = |in_ready;

  // One-hot AND-OR payload select and index encode for the granted channel.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) sel_data = sel_data | in_data[i*DATA_W +: DATA_W];
    end
    grant_w           = '0;
    grant_w[N_CH-1:0] = grant;
    sel_idx_w         = onehot_to_idx(grant_w, N_CH);
    sel_idx           = sel_idx_w[CH_W-1:0];
  end

  assign unused_idx = ^sel_idx_w;

  // Output stage next-state: load new beat, drain to empty, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
`ifndef RR_MUX_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (load) begin
      if (xfer) begin
        out_valid_d = 1'b1;
        out_data_d  = sel_data;
        out_chan_d  = sel_idx;
`ifndef RR_MUX_FIXED_PRIO_EN
        ptr_d       = sel_idx;
`endif
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Output register and priority pointer; pointer resets so channel 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr_q       <= CH_W'(N_CH - 1);
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
`ifndef RR_MUX_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: directed and randomized checks of rr_mux (N_CH=8, DATA_W=8)
// against a behavioural model. Honours RR_MUX_FIXED_PRIO_EN.
module tb_rr_mux;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    out_chan;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   m_ptr;
  bit   m_valid;
  int   m_data;
  int   m_chan;
  int   last_acc;

  rr_mux #(
    .N_CH   (N),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner among requesting channels, -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef RR_MUX_FIXED_PRIO_EN
    for (int c = 0; c < N; c++) if (v[c]) return c;
`else
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
`endif
    return -1;
  endfunction

  function automatic int byte_of(input logic [N*DW-1:0] d, input int c);
    logic [N*DW-1:0] s;
    s = d >> (c * DW);
    return int'(s[DW-1:0]);
  endfunction

  task automatic model_reset();
    m_ptr = N - 1; m_valid = 0; m_data = 0; m_chan = 0;
  endtask

  // Entered shortly after a rising edge; drives one cycle, checks in_ready, then outputs.
  task automatic cycle(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic r);
    int  g;
    bit  ld;
    logic [N-1:0] exp_rdy;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    ld = !m_valid || r;
    g  = pick(v, m_ptr);
    exp_rdy = '0;
    if (ld && g >= 0) exp_rdy[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    last_acc = -1;
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1; m_data = byte_of(d, g); m_chan = g; last_acc = g;
`ifndef RR_MUX_FIXED_PRIO_EN
        m_ptr = g;
`endif
      end else begin
        m_valid = 0;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_chan",  32'(out_chan),  32'(m_chan));
  endtask

  logic [N-1:0]    pv;
  logic [N*DW-1:0] pd;

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

`ifndef RR_MUX_FIXED_PRIO_EN
    // Fairness: all valid, sequence 0..7,0..7
    for (int i = 0; i < 16; i++) begin
      cycle(8'hFF, {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00}, 1'b1);
      check("fair_chan",  32'(out_chan),  32'(i % 8));
      check("fair_valid", 32'(out_valid), 32'd1);
    end
    // Single beat on ch5
    in_valid = 8'h20; in_data = 64'hA5 << 40; out_ready = 1'b1; #1;
    check("single_rdy", 32'(in_ready), 32'h20);
    cycle(8'h20, 64'hA5 << 40, 1'b1);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_chan", 32'(out_chan), 32'd5);
    cycle(8'h00, '0, 1'b1);
    // Backpressure: ch2 granted, then 5 stalled cycles, then ch3
    cycle(8'h0C, 64'h0000_0000_3C2C_0000, 1'b1);
    check("bp_first", 32'(out_chan), 32'd2);
    for (int i = 0; i < 5; i++) begin
      cycle(8'h0C, 64'h0000_0000_3C2C_0000, 1'b0);
      check("bp_rdy0", 32'(in_ready), 32'd0);
      check("bp_hold", 32'(out_data), 32'h2C);
    end
    in_valid = 8'h08; in_data = 64'h0000_0000_3C00_0000; out_ready = 1'b1; #1;
    check("bp_release_rdy", 32'(in_ready), 32'h08);
    cycle(8'h08, 64'h0000_0000_3C00_0000, 1'b1);
    check("bp_release_chan", 32'(out_chan), 32'd3);
    // Wrap and skip: ptr=6 then 8'h05 -> 0,2,0
    cycle(8'h40, 64'h0066_0000_0000_0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(8'h05, 64'h0000_0000_0002_0000 | 64'(8'h10 + i), 1'b1);
      check("wrap_chan", 32'(out_chan), (i == 1) ? 32'd2 : 32'd0);
    end
`else
    for (int i = 0; i < 12; i++) begin
      cycle(8'h81, 64'hF700_0000_0000_00F0, 1'b1);
      check("fixed_chan", 32'(out_chan), 32'd0);
      check("fixed_no7",  32'(in_ready[7]), 32'd0);
    end
`endif

    // Reset mid-run with a held beat
    cycle(8'h10, 64'h0000_00C4_0000_0000, 1'b1);
    cycle(8'h00, '0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_chan",  32'(out_chan),  32'd0);
    check("midrst_data",  32'(out_data),  32'd0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cycle(8'hFF, 64'h8877_6655_4433_2211, 1'b1);
    check("post_rst_chan", 32'(out_chan), 32'd0);

    // Randomized traffic; pending beats keep their data until accepted
    pv = '0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        if (!pv[c]) begin
          pv[c] = ($urandom_range(0, 2) == 0);
          pd[c*DW +: DW] = DW'($urandom);
        end
      end
      cycle(pv, pd, ($urandom_range(0, 3) != 0));
      if (last_acc >= 0) pv[last_acc] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
